// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART types, timing defaults and helpers
//
// Shared by uart_tx and its receive counterpart. Both sides must use the
// same prescaler for a working link.
//   tx_state_e             : transmitter FSM state encoding
//   UART_DEFAULT_PRESCALER : default clock cycles per bit
//   cnt_width()            : bit width of a down-counter that holds PRESCALER-1

package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned UART_DEFAULT_PRESCALER = 1155;

    function automatic int unsigned cnt_width(input int unsigned p);
        return (p < 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - loadable bit-period down-counter with tick at zero
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset (counter -> PRESCALER-1)
//   hold   in  keep the counter parked at PRESCALER-1 (idle line)
//   reload in  restart the bit period at PRESCALER-1
//   tick   out high for the one cycle the counter sits at zero

module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int unsigned PRESCALER = UART_DEFAULT_PRESCALER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic reload,
    output logic tick
);

    localparam int unsigned   CW  = cnt_width(PRESCALER);
    localparam logic [CW-1:0] TOP = CW'(PRESCALER - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at zero; the only way back up is an explicit reload.
    always_comb begin
        cnt_d = cnt_q;
        if (hold || reload) begin
            cnt_d = TOP;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= TOP;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-byte holding register
//
// Ports:
//   CLK   in  system clock, rising edge
//   RST   in  asynchronous active-low reset
//   STBi  in  producer strobe, DATi valid (held until ACKi)
//   DATi  in  byte to transmit
//   ACKi  out one-cycle pulse: DATi accepted into the holding register
//   TXD   out registered serial line, idles high, LSB first
//   BUSY  out registered: frame in progress or holding register full

module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned PRESCALER = UART_DEFAULT_PRESCALER
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STBi,
    input  logic [7:0] DATi,
    output logic       ACKi,
    output logic       TXD,
    output logic       BUSY
);

    tx_state_e  state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       ack_q, ack_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;

    logic       tick;
    logic       reload;
    logic       in_idle;

    assign in_idle = (state_q == ST_IDLE);

    uart_baud_tick #(
        .PRESCALER (PRESCALER)
    ) u_baud (
        .clk    (CLK),
        .rst_n  (RST),
        .hold   (in_idle),
        .reload (reload),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        ack_d      = 1'b0;
        txd_d      = txd_q;
        reload     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    shift_d    = hold_q;
                    hold_vld_d = 1'b0;
                    txd_d      = 1'b0;
                    reload     = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    reload    = 1'b1;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    reload = 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    reload = 1'b1;
                    // A queued byte chains straight into its start bit.
                    if (hold_vld_q) begin
                        shift_d    = hold_q;
                        hold_vld_d = 1'b0;
                        txd_d      = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept looks at the registered valid, so a byte unloaded this
        // edge frees the register only for the following edge. Blocking on
        // ack_q keeps a producer that is still dropping STBi from resending.
        if (STBi && !hold_vld_q && !ack_q) begin
            hold_d     = DATi;
            hold_vld_d = 1'b1;
            ack_d      = 1'b1;
        end

        busy_d = (state_d != ST_IDLE) || hold_vld_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ack_q      <= ack_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign ACKi = ack_q;
    assign TXD  = txd_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a serial-line scoreboard

module tb_uart_tx;

    localparam int P = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       STBi;
    logic [7:0] DATi;
    logic       ACKi;
    logic       TXD;
    logic       BUSY;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    logic [7:0] sb[$];

    uart_tx #(
        .PRESCALER (P)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .STBi (STBi),
        .DATi (DATi),
        .ACKi (ACKi),
        .TXD  (TXD),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (ACKi === 1'b1) ack_cnt <= ack_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Offer one byte and hold it until ACKi; the byte enters the scoreboard
    // at acceptance. Returns the cycle number of the ACKi sample.
    task automatic send_byte(input logic [7:0] b, output int ac);
        int n;
        n    = 0;
        STBi = 1'b1;
        DATi = b;
        do begin
            @(negedge CLK);
            n++;
        end while (ACKi !== 1'b1 && n < 200);
        check("ack_seen", {31'd0, ACKi === 1'b1}, 32'd1);
        if (ACKi === 1'b1) sb.push_back(b);
        ac   = cyc;
        STBi = 1'b0;
    endtask

    // Wait for a start bit, then demand every level lasts exactly P samples.
    // Returns the received byte and the cycle of the first start-bit sample.
    task automatic recv_frame(output logic [7:0] d, output int st);
        int n;
        int bad;
        logic [7:0] exp;
        d   = 8'h00;
        st  = 0;
        bad = 0;
        n   = 0;
        while (TXD !== 1'b0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("start_seen", {31'd0, TXD === 1'b0}, 32'd1);
        if (TXD !== 1'b0) return;
        st = cyc;
        for (int k = 1; k < P; k++) begin
            @(negedge CLK);
            if (TXD !== 1'b0) bad++;
        end
        for (int b = 0; b < 8; b++) begin
            @(negedge CLK);
            d[b] = TXD;
            for (int k = 1; k < P; k++) begin
                @(negedge CLK);
                if (TXD !== d[b]) bad++;
            end
        end
        for (int k = 0; k < P; k++) begin
            @(negedge CLK);
            if (TXD !== 1'b1) bad++;
        end
        check("frame_shape", bad, 0);
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("rx_byte", {24'd0, d}, {24'd0, exp});
        end
    endtask

    initial begin
        logic [7:0] d;
        int a1, a2, a3, s1, s2, s3, acks0, n;

        // Reset with a strobe pending: nothing may be taken.
        RST  = 1'b0;
        STBi = 1'b1;
        DATi = 8'hFF;
        repeat (3) @(negedge CLK);
        check("rst_txd", {31'd0, TXD}, 32'd1);
        check("rst_ack", {31'd0, ACKi}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        STBi = 1'b0;
        RST  = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_busy", {31'd0, BUSY}, 32'd0);
        check("post_rst_acks", ack_cnt, 0);

        // Single byte 0x55.
        acks0 = ack_cnt;
        fork
            send_byte(8'h55, a1);
            recv_frame(d, s1);
        join
        check("single_start_lat", s1 - a1, 1);
        check("single_busy_stop", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        check("single_busy_end", {31'd0, BUSY}, 32'd0);
        check("single_ack_pulses", ack_cnt - acks0, 1);
        repeat (3) @(negedge CLK);

        // Back-to-back 0xA5, 0x3C.
        fork
            begin
                send_byte(8'hA5, a1);
                send_byte(8'h3C, a2);
            end
            begin
                recv_frame(d, s1);
                recv_frame(d, s2);
            end
        join
        check("b2b_ack_gap_le2", {31'd0, (a2 - a1) <= 2}, 32'd1);
        check("b2b_no_gap", s2 - s1, 10 * P);
        @(negedge CLK);
        check("b2b_busy_end", {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);

        // Buffer full: third byte waits for the holding register to unload.
        acks0 = ack_cnt;
        fork
            begin
                send_byte(8'h11, a1);
                send_byte(8'h22, a2);
                send_byte(8'h33, a3);
            end
            begin
                recv_frame(d, s1);
                recv_frame(d, s2);
                recv_frame(d, s3);
            end
        join
        check("full_ack3_after_unload", a3 - s2, 1);
        check("full_ack_pulses", ack_cnt - acks0, 3);
        check("full_gap12", s2 - s1, 10 * P);
        check("full_gap23", s3 - s2, 10 * P);
        repeat (3) @(negedge CLK);

        // Reset during BIT3 of 0xF0.
        send_byte(8'hF0, a1);
        n = 0;
        while (TXD !== 1'b0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("mid_start_seen", {31'd0, TXD === 1'b0}, 32'd1);
        repeat (4 * P + 1) @(negedge CLK);
        check("mid_bit3_level", {31'd0, TXD}, 32'd0);
        #1 RST = 1'b0;
        #1;
        check("mid_txd_async", {31'd0, TXD}, 32'd1);
        check("mid_busy_async", {31'd0, BUSY}, 32'd0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        fork
            send_byte(8'h81, a1);
            recv_frame(d, s1);
        join
        check("mid_new_start_lat", s1 - a1, 1);
        repeat (3) @(negedge CLK);

        // Loopback: 256 random bytes, in order, no loss.
        fork
            begin
                int ac;
                for (int i = 0; i < 256; i++) send_byte(8'($urandom_range(0, 255)), ac);
            end
            begin
                logic [7:0] rd;
                int rs;
                for (int i = 0; i < 256; i++) recv_frame(rd, rs);
            end
        join
        check("loop_sb_drained", sb.size(), 0);
        @(negedge CLK);
        check("loop_busy_end", {31'd0, BUSY}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
